key_schedule_encrypt: RTL
=========================

KEY_SCHEDULE_ENCRYPT -- requirements
Module: key_schedule_encrypt

Interface
REQ-001 The block SHALL have a single clock CLK, and its reset SHALL be synchronous and active-low, named RST_N.
REQ-002 Parameters: NUM_KEYS, default 96, total round-key bytes produced per run, a multiple of 3; KEY_RESET, default 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, key register reset value.
REQ-003 CLK  input  1  system clock; all state changes on the rising edge.
REQ-004 RST_N  input  1  synchronous active-low reset.
REQ-005 key_load  input  1  capture key_in into the key register; honoured in IDLE only.
REQ-006 key_in  input  128  master key; byte B[0]=key_in[127:120] through B[15]=key_in[7:0].
REQ-007 start  input  1  begin a run; honoured in IDLE only.
REQ-008 out_ready  input  1  consumer accepts the current triple.
REQ-009 out_valid  output  1  K_a/K_b/K_c/idx hold a valid triple.
REQ-010 K_a, K_b, K_c  output  8 each  round-key bytes K_n, K_n+1, K_n+2.
REQ-011 idx  output  7  index n of K_a (1, 4, ..., NUM_KEYS-2).
REQ-012 busy  output  1  high in RUN.
REQ-013 done  output  1  one-cycle pulse after the last triple is accepted.

Function
REQ-014 Round-key byte SHALL be K_n = {1'b0, n[6:0]} XOR B[(n-1) mod 16], where n ranges from 1 to NUM_KEYS; for example, n=16 uses B[15] and n=17 uses B[0].
REQ-015 Key schedule order SHALL be ascending: beat c (1..NUM_KEYS/3) carries n = 3c-2, 3c-1, 3c, the reverse traversal of the decrypt schedule, with identical byte values for identical n.
REQ-016 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-017 IDLE to RUN transition: on start=1, beat counter c SHALL be set to 1.
REQ-018 In RUN, when out_valid=0 or out_ready=1, and beats remain, the block SHALL register the beat-c bytes, set out_valid=1 and increment c.
REQ-019 The first out_valid SHALL assert exactly 2 cycles after the cycle in which start is sampled, provided out_ready imposes no stall.
REQ-020 Handshake: a transfer occurs when out_valid=1 and out_ready=1; while out_valid=1 and out_ready=0, K_a/K_b/K_c/idx SHALL remain stable.
REQ-021 At full throughput (out_ready held at 1), one triple SHALL be produced per cycle, giving NUM_KEYS/3 consecutive valid cycles.
REQ-022 When the last triple transfers, out_valid SHALL drop the next cycle and the FSM SHALL enter DONE.
REQ-023 DONE SHALL assert done for one cycle and return to IDLE.
REQ-024 If key_load and start are both high in IDLE, the new key SHALL be captured and the run SHALL use the new key.
REQ-025 key_load and start SHALL be ignored in RUN and DONE.
REQ-026 Counter width SHALL be 7 bits, and n SHALL never exceed NUM_KEYS; there is no wrap-around within a run.

Reset
REQ-027 With RST_N=0 at a clock edge, the FSM SHALL go to IDLE, the key register SHALL load KEY_RESET, and c, out_valid, K_a, K_b, K_c, idx, busy and done SHALL all be 0.
REQ-028 A reset mid-run SHALL abort the run: no done pulse, and out_valid low from the next cycle.

Structure
REQ-029 The shared package SHALL hold NUM_KEYS_DEFAULT=96, KEYS_PER_BEAT=3, KEY_RESET_DEFAULT, the FSM state encoding, and the key-byte select function, which is shared with the decrypt schedule.
REQ-030 One sub-module, key_byte_sched (combinational: n[6:0], key[127:0] -> K_n[7:0]), SHALL be instantiated three times.

Verification
REQ-031 Reset, then start with no key_load, out_ready=1: the first beat SHALL be idx=1, bytes FE/FD/FC; the last beat SHALL be idx=94, bytes A1/A0/9F; done SHALL pulse once, 32 beats in total.
REQ-032 Load key 00010203_04050607_08090A0B_0C0D0E0F, then start: beat 1 SHALL be 01/03/01; beat 6 (idx=16) SHALL be 1F/11/13.
REQ-033 Toggle out_ready randomly during a run: outputs SHALL stay stable while stalled, no beat SHALL be lost or duplicated, and the idx sequence SHALL be 1, 4, ..., 94.
REQ-034 Assert key_load with a new key at beat 10: the running bytes SHALL be unchanged, and the following run SHALL still use the previously loaded key.
REQ-035 Drop RST_N at beat 15: all outputs SHALL be 0 and the FSM in IDLE the next cycle with no done pulse; a subsequent start SHALL yield beat 1 computed with KEY_RESET.
REQ-036 For every n from 1 to 96, K_n SHALL equal the decrypt key schedule's output for the same index and key.

Source files
------------

// File: rtl/key_schedule_encrypt_pkg.sv
// Shared definitions for the encrypt/decrypt key schedules.
// Latency: none (constants, types and a pure function only).
// Backpressure: not applicable.
package key_schedule_encrypt_pkg;

  localparam int NUM_KEYS_DEFAULT = 96;
  localparam int KEYS_PER_BEAT    = 3;
  localparam logic [127:0] KEY_RESET_DEFAULT = {128{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // K_n = {0, n} ^ B[(n-1) mod 16], with B[0] in key[127:120].
  // The 4-bit truncation of n-1 gives the modulo-16 wrap for free.
  function automatic logic [7:0] key_byte(input logic [6:0] n, input logic [127:0] key);
    logic [3:0]   sel;
    logic [127:0] shifted;
    sel     = 4'(n - 7'd1);
    shifted = key << {sel, 3'b000};
    return {1'b0, n} ^ shifted[127:120];
  endfunction

endpackage

// File: rtl/key_schedule_encrypt_key_byte_sched.sv
// One round-key byte from index n and the current master key.
// Latency: combinational.
// Backpressure: not applicable.
module key_byte_sched
  import key_schedule_encrypt_pkg::*;
(
  input  logic [6:0]   n,
  input  logic [127:0] key,
  output logic [7:0]   kn
);

  assign kn = key_byte(n, key);

endmodule

// File: rtl/key_schedule_encrypt.sv
// Streams the ascending round-key schedule as byte triples, one per beat.
// Latency: first triple valid 2 cycles after start is sampled, then 1 per cycle.
// Backpressure: out_ready low holds the current triple stable; no beat is skipped.
module key_schedule_encrypt
  import key_schedule_encrypt_pkg::*;
#(
  parameter int           NUM_KEYS  = NUM_KEYS_DEFAULT,
  parameter logic [127:0] KEY_RESET = KEY_RESET_DEFAULT
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         key_load,
  input  logic [127:0] key_in,
  input  logic         start,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [7:0]   K_a,
  output logic [7:0]   K_b,
  output logic [7:0]   K_c,
  output logic [6:0]   idx,
  output logic         busy,
  output logic         done
);

  localparam logic [6:0] NBEATS = 7'(NUM_KEYS / KEYS_PER_BEAT);

  state_t       state;
  logic [6:0]   c;
  logic [127:0] key_q;
  logic [6:0]   n0, n1, n2;
  logic [7:0]   kb0, kb1, kb2;

  // Beat c carries n = 3c-2, 3c-1, 3c; c stays <= NBEATS+1 so 7 bits never wrap.
  assign n2 = (c << 1) + c;
  assign n1 = n2 - 7'd1;
  assign n0 = n2 - 7'd2;

  key_byte_sched u_kb0 (.n(n0), .key(key_q), .kn(kb0));
  key_byte_sched u_kb1 (.n(n1), .key(key_q), .kn(kb1));
  key_byte_sched u_kb2 (.n(n2), .key(key_q), .kn(kb2));

  // Control FSM with key register and registered outputs.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      key_q     <= KEY_RESET;
      c         <= 7'd0;
      out_valid <= 1'b0;
      K_a       <= 8'd0;
      K_b       <= 8'd0;
      K_c       <= 8'd0;
      idx       <= 7'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          // A simultaneous load lands before the first beat is computed,
          // so a run started in the same cycle uses the new key.
          if (key_load) key_q <= key_in;
          if (start) begin
            state <= ST_RUN;
            c     <= 7'd1;
            busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (!out_valid || out_ready) begin
            if (c <= NBEATS) begin
              K_a       <= kb0;
              K_b       <= kb1;
              K_c       <= kb2;
              idx       <= n0;
              out_valid <= 1'b1;
              c         <= c + 7'd1;
            end else begin
              // Last triple just transferred.
              out_valid <= 1'b0;
              state     <= ST_DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
